// File: rtl/uart_rx_deser_pkg.sv
// ============================================================================
// Module      : uart_rx_deser_pkg
// Description : Shared UART definitions: FSM state encodings and parity polarity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_deser_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE       = 3'd0;
    localparam uart_state_t ST_START      = 3'd1;
    localparam uart_state_t ST_DATA       = 3'd2;
    localparam uart_state_t ST_PARITY     = 3'd3;
    localparam uart_state_t ST_STOP       = 3'd4;
    localparam uart_state_t ST_BREAK_WAIT = 3'd5;

    // XOR over data plus parity bit equals this value on a good frame (odd parity)
    localparam logic PARITY_ODD = 1'b1;

endpackage : uart_rx_deser_pkg

`default_nettype wire

// File: rtl/uart_rx_deser_if.sv
// ============================================================================
// Module      : uart_rx_deser_if
// Description : Serial input and received-word bundle of the UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_deser_if #(
    parameter int WORD_WIDTH = 8
);
    logic                  tick;
    logic                  rxd;
    logic                  parity;
    logic [WORD_WIDTH-1:0] dout;
    logic                  rx_done;
    logic                  parity_err;
    logic                  frame_err;
    logic                  active;

    modport master (
        output tick, rxd, parity,
        input  dout, rx_done, parity_err, frame_err, active
    );

    modport slave (
        input  tick, rxd, parity,
        output dout, rx_done, parity_err, frame_err, active
    );
endinterface : uart_rx_deser_if

`default_nettype wire

// File: rtl/uart_rx_deser_sync2.sv
// ============================================================================
// Module      : uart_sync2
// Description : Two-flop synchronizer, resets to 1 (idle level of a UART line).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync2 (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic async_i,
    output logic      sync_o
);
    logic [1:0] meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 2'b11;
        end else begin
            meta_q <= {meta_q[0], async_i};
        end
    end

    assign sync_o = meta_q[1];
endmodule : uart_sync2

`default_nettype wire

// File: rtl/uart_rx_deser.sv
// ============================================================================
// Module      : uart_rx_deser
// Description : Oversampling UART receiver with optional odd parity and break hold-off.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_deser
    import uart_rx_deser_pkg::*;
#(
    parameter int WORD_WIDTH   = 8,
    parameter int OVERSAMPLING = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    uart_rx_deser_if.slave  bus
);
    localparam int TW = $clog2(OVERSAMPLING);
    localparam int BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLING / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_WIDTH - 1);

    logic                  rxd_s;
    uart_state_t           state_q,    state_d;
    logic [TW-1:0]         tick_ctr_q, tick_ctr_d;
    logic [BW-1:0]         bit_ctr_q,  bit_ctr_d;
    logic [WORD_WIDTH-1:0] shift_q,    shift_d;
    logic                  par_en_q,   par_en_d;
    logic                  pbit_q,     pbit_d;
    logic [WORD_WIDTH-1:0] dout_q,     dout_d;
    logic                  rx_done_q,  rx_done_d;
    logic                  perr_q,     perr_d;
    logic                  ferr_q,     ferr_d;
    logic                  ctr_zero;

    uart_sync2 u_sync_rxd (
        .clk     (clk),
        .rst     (rst),
        .async_i (bus.rxd),
        .sync_o  (rxd_s)
    );

    assign ctr_zero = (tick_ctr_q == '0);

    always_comb begin
        state_d    = state_q;
        tick_ctr_d = tick_ctr_q;
        bit_ctr_d  = bit_ctr_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        pbit_d     = pbit_q;
        dout_d     = dout_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        rx_done_d  = 1'b0;

        if (bus.tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state_d    = ST_START;
                        tick_ctr_d = TICK_HALF;
                        par_en_d   = bus.parity;
                    end
                end
                ST_START: begin
                    if (!ctr_zero) begin
                        tick_ctr_d = tick_ctr_q - TW'(1);
                    end else if (!rxd_s) begin
                        state_d    = ST_DATA;
                        tick_ctr_d = TICK_FULL;
                        bit_ctr_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (!ctr_zero) begin
                        tick_ctr_d = tick_ctr_q - TW'(1);
                    end else begin
                        // LSB-first: each new bit enters at the top and walks down
                        shift_d    = WORD_WIDTH'({rxd_s, shift_q} >> 1);
                        bit_ctr_d  = bit_ctr_q + BW'(1);
                        tick_ctr_d = TICK_FULL;
                        if (bit_ctr_q == BIT_LAST) begin
                            state_d = par_en_q ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (!ctr_zero) begin
                        tick_ctr_d = tick_ctr_q - TW'(1);
                    end else begin
                        pbit_d     = rxd_s;
                        tick_ctr_d = TICK_FULL;
                        state_d    = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (!ctr_zero) begin
                        tick_ctr_d = tick_ctr_q - TW'(1);
                    end else begin
                        dout_d    = shift_q;
                        rx_done_d = 1'b1;
                        ferr_d    = ~rxd_s;
                        perr_d    = par_en_q & ((^{shift_q, pbit_q}) != PARITY_ODD);
                        // Leaving at mid-stop lets a back-to-back start bit be caught
                        state_d   = rxd_s ? ST_IDLE : ST_BREAK_WAIT;
                    end
                end
                ST_BREAK_WAIT: begin
                    if (rxd_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_ctr_q <= '0;
            bit_ctr_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            pbit_q     <= 1'b0;
            dout_q     <= '0;
            rx_done_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_ctr_q <= tick_ctr_d;
            bit_ctr_q  <= bit_ctr_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            pbit_q     <= pbit_d;
            dout_q     <= dout_d;
            rx_done_q  <= rx_done_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.rx_done    = rx_done_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.active     = (state_q != ST_IDLE);

endmodule : uart_rx_deser

`default_nettype wire

// File: tb/tb_uart_rx_deser.sv
// ============================================================================
// Module      : tb_uart_rx_deser
// Description : Scoreboard bench for uart_rx_deser: directed and random frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_deser;
    localparam int W   = 8;
    localparam int OS  = 16;
    localparam int BIT = OS * 4;

    typedef struct packed {
        logic [W-1:0] data;
        logic         perr;
        logic         ferr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    uart_rx_deser_if #(.WORD_WIDTH(W)) bus ();

    uart_rx_deser #(
        .WORD_WIDTH   (W),
        .OVERSAMPLING (OS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        int tcnt;
        tcnt     = 0;
        bus.tick = 1'b0;
        forever begin
            @(negedge clk);
            tcnt     = (tcnt + 1) % 4;
            bus.tick = (tcnt == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: every rx_done pops one expected frame; pulse must last one clk
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (prev) begin
                check("rx_done_width", {31'd0, bus.rx_done}, 32'd0);
            end else if (bus.rx_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rx_done: got dout=%0h expected no frame at %0t",
                             bus.dout, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("dout",       {24'd0, bus.dout},         {24'd0, e.data});
                    check("parity_err", {31'd0, bus.parity_err},   {31'd0, e.perr});
                    check("frame_err",  {31'd0, bus.frame_err},    {31'd0, e.ferr});
                end
            end
            prev = (bus.rx_done === 1'b1);
        end
    end

    task automatic drive_bit(input logic v, input int n);
        bus.rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    // Reference: odd parity means total ones over data+pbit is odd
    task automatic send_frame(input logic [W-1:0] d, input bit pen, input bit pgood,
                              input bit stop, input int bclk, input bit flip_par);
        exp_t e;
        logic pbit;
        int   ones;
        ones   = $countones(d);
        pbit   = pgood ? ((ones % 2) == 0) : ((ones % 2) == 1);
        e.data = d;
        e.perr = pen && (((ones + int'(pbit)) % 2) == 0);
        e.ferr = !stop;
        exp_q.push_back(e);
        bus.parity = pen;
        drive_bit(1'b0, bclk);
        if (flip_par) bus.parity = !pen;
        for (int i = 0; i < W; i++) drive_bit(d[i], bclk);
        if (pen) drive_bit(pbit, bclk);
        drive_bit(stop, bclk);
        bus.rxd = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending frames expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic saw_active;
        bus.rxd    = 1'b1;
        bus.parity = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_dout",       {24'd0, bus.dout},      32'd0);
        check("reset_rx_done",    {31'd0, bus.rx_done},   32'd0);
        check("reset_parity_err", {31'd0, bus.parity_err}, 32'd0);
        check("reset_frame_err",  {31'd0, bus.frame_err}, 32'd0);
        check("reset_active",     {31'd0, bus.active},    32'd0);
        rst = 1'b0;
        idle(2 * BIT);

        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, BIT, 1'b0);
        wait_drain(2 * BIT);
        idle(BIT);
        check("active_after_frame", {31'd0, bus.active}, 32'd0);

        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, BIT, 1'b0);
        idle(BIT);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, BIT, 1'b1);
        wait_drain(2 * BIT);
        idle(BIT);

        // Start-bit glitch: 5 ticks low
        saw_active = 1'b0;
        bus.rxd    = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.active) saw_active = 1'b1;
        end
        bus.rxd = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_active_seen", {31'd0, saw_active}, 32'd1);
        check("glitch_active_low",  {31'd0, bus.active}, 32'd0);
        idle(BIT);

        // Break: one framing-error frame, then held off until line returns high
        exp_q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1});
        bus.parity = 1'b0;
        drive_bit(1'b0, 12 * BIT);
        wait_drain(2 * BIT);
        check("break_active", {31'd0, bus.active}, 32'd1);
        idle(2 * BIT);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, BIT, 1'b0);
        wait_drain(2 * BIT);
        idle(BIT);

        // Back-to-back, nominal then +-3% skew
        send_frame(8'h01, 1'b0, 1'b1, 1'b1, BIT, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1, BIT, 1'b0);
        wait_drain(2 * BIT);
        idle(BIT);
        send_frame(8'h01, 1'b0, 1'b1, 1'b1, 62, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 62, 1'b0);
        wait_drain(2 * BIT);
        idle(BIT);
        send_frame(8'h01, 1'b0, 1'b1, 1'b1, 66, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 66, 1'b0);
        wait_drain(2 * BIT);
        idle(BIT);

        // Reset in bit 4 of 0x81; the line is released when reset hits
        bus.parity = 1'b0;
        drive_bit(1'b0, BIT);
        drive_bit(1'b1, BIT);
        drive_bit(1'b0, BIT);
        drive_bit(1'b0, BIT);
        drive_bit(1'b0, BIT);
        drive_bit(1'b0, BIT / 2);
        rst     = 1'b1;
        bus.rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_dout",       {24'd0, bus.dout},       32'd0);
        check("rst_rx_done",    {31'd0, bus.rx_done},    32'd0);
        check("rst_parity_err", {31'd0, bus.parity_err}, 32'd0);
        check("rst_frame_err",  {31'd0, bus.frame_err},  32'd0);
        check("rst_active",     {31'd0, bus.active},     32'd0);
        idle(12 * BIT);
        send_frame(8'h81, 1'b0, 1'b1, 1'b1, BIT, 1'b0);
        wait_drain(2 * BIT);
        idle(BIT);

        for (int k = 0; k < 24; k++) begin
            logic [W-1:0] d;
            bit pen, pgood, stop, flip;
            d     = W'($urandom);
            pen   = 1'($urandom % 2);
            pgood = ($urandom % 4) != 0;
            stop  = ($urandom % 6) != 0;
            flip  = 1'($urandom % 2);
            send_frame(d, pen, pgood, stop, $urandom_range(62, 66), flip);
            wait_drain(2 * BIT);
            idle(stop ? $urandom_range(0, BIT) : BIT);
        end
        idle(2 * BIT);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_rx_deser

`default_nettype wire
